cplx_recursion: RTL and testbench
=================================

CPLX_RECURSION -- requirements
Module: cplx_recursion

Interface
REQ-001 Parameter WIDTH, default 24: signed fixed-point width of each real/imaginary component.
REQ-002 Parameter FRAC, default 16: number of fractional bits in every data word and coefficient.
REQ-003 Parameter real LAMBDA_RE, default 0.5: real part of the recursion pole.
REQ-004 Parameter real LAMBDA_IM, default 0.0: imaginary part of the recursion pole.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 clear  input  1  synchronous flush of recursion state.
REQ-008 in_valid  input  1  in_data holds a valid LUT sum.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  complex (2x WIDTH)  LUT output f[k] (fields r, i).
REQ-011 out_valid  output  1  out_data holds a valid recursion result.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  complex (2x WIDTH)  state m[k].
REQ-014 sat  output  1  sticky flag: a saturation has occurred since the last reset or clear.

Function
REQ-015 The block SHALL compute m[k] = LAMBDA*m[k-1] + f[k] in complex fixed point, with m[-1] = 0.
REQ-016 Coefficients SHALL be converted at elaboration to round(LAMBDA_x * 2^FRAC), held in WIDTH signed bits.
REQ-017 The FSM SHALL have states IDLE, MUL and ADD; it SHALL leave IDLE only on in_valid && in_ready.
REQ-018 On acceptance (edge k), the block SHALL capture in_data and move IDLE->MUL.
REQ-019 In MUL, the block SHALL register the four full-precision (2*WIDTH) products of LAMBDA and m, then move MUL->ADD at edge k+1.
REQ-020 In ADD, the block SHALL form re = pr_rr - pr_ii and im = pr_ri + pr_ir.
REQ-021 In ADD, each sum SHALL be rounded half-up (add 2^(FRAC-1), arithmetic shift right by FRAC).
REQ-022 In ADD, the captured f SHALL be added, and the result saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] per component.
REQ-023 At edge k+2, the ADD result SHALL be written to m and out_data, out_valid SHALL be set, and the FSM SHALL move ADD->IDLE; latency is 2 cycles, throughput 1 sample per 3 cycles.
REQ-024 in_ready SHALL be high only in IDLE, and only when !out_valid || out_ready.
REQ-025 out_valid SHALL clear on out_valid && out_ready; out_data SHALL remain stable while out_valid && !out_ready.
REQ-026 Any component clipped in ADD SHALL set sat; sat SHALL hold until clear or reset.
REQ-027 clear SHALL have priority over every other event.
REQ-028 On clear, the block SHALL zero m and out_data, deassert out_valid and sat, abort any in-flight sample and return to IDLE.
REQ-029 An in_valid coincident with clear SHALL NOT be accepted (in_ready low while clear is high).

Reset
REQ-030 While rst_n is low: FSM=IDLE, m=0, out_data=0, out_valid=0, sat=0, in_ready=0; in_ready SHALL rise the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard the in-flight sample, with no partial output.

Structure
REQ-032 The complex typedef (fields r, i, signed WIDTH) and the real-to-fixed conversion function SHALL live in the shared filter package, common with the LUT stage.
REQ-033 Sub-module cplx_mult SHALL hold the registered 4-product multiplier; FSM, rounding, saturation and handshake SHALL stay in cplx_recursion.

Verification (WIDTH=16, FRAC=12, so 1.0 = 4096)
REQ-034 Step: LAMBDA=0.5+0j, in (4096,0) x3, out_ready=1 -> out (4096,0), (6144,0), (7168,0); each out_valid is 2 cycles after acceptance.
REQ-035 Rotation: LAMBDA=0+1j, in (4096,0) then (0,0) x3 -> out (4096,0), (0,4096), (-4096,0), (0,-4096).
REQ-036 Saturation: LAMBDA=1.0+0j, in (30000,0) x2 -> out (30000,0) then (32767,0) with sat=1; after clear, sat=0 and next in (100,0) -> (100,0).
REQ-037 Backpressure: out_ready held low 5 cycles after a result -> out_data stable, in_ready low throughout; one cycle after out_ready rises, in_ready=1.
REQ-038 Reset during MUL and clear during ADD -> no out_valid pulse; the next sample (4096,0) yields (4096,0).

Source files
------------

// File: rtl/cplx_recursion_pkg.sv
// ---------------------------------------------------------------------------
// cplx_recursion_pkg
// Shared filter package: complex sample type for the default filter format,
// the recursion FSM state encoding and the real-to-fixed conversion used to
// turn real-valued coefficients into fixed-point constants at elaboration.
// No ports (package).
// ---------------------------------------------------------------------------
package cplx_recursion_pkg;

   // Default filter number format, common with the LUT stage.
   localparam int FILT_W    = 24;
   localparam int FILT_FRAC = 16;

   // Complex sample in the default filter format. Packed so {r, i} places
   // the real part in the upper half of a 2*FILT_W bus.
   typedef struct packed {
      logic signed [FILT_W-1:0] r;
      logic signed [FILT_W-1:0] i;
   } cplx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2
   } rec_state_t;

   // round(x * 2^frac); the real-to-integer cast rounds to nearest.
   function automatic longint to_fixed(input real x, input int frac);
      real scale;
      scale = real'(longint'(1) << frac);
      return longint'(x * scale);
   endfunction

endpackage

// File: rtl/cplx_recursion_mult.sv
// ---------------------------------------------------------------------------
// cplx_mult
// Registered four-product complex multiplier. When en is high, the four
// full-precision partial products of a*b are captured on the rising edge.
// Ports:
//   clk                     clock
//   en                      capture enable
//   a_r, a_i                first operand (coefficient), signed WIDTH
//   b_r, b_i                second operand (state), signed WIDTH
//   pr_rr, pr_ii            a_r*b_r, a_i*b_i, signed 2*WIDTH
//   pr_ri, pr_ir            a_r*b_i, a_i*b_r, signed 2*WIDTH
// ---------------------------------------------------------------------------
module cplx_mult
   import cplx_recursion_pkg::*;
#(
   parameter int WIDTH = FILT_W
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic signed [WIDTH-1:0]   a_r,
   input  logic signed [WIDTH-1:0]   a_i,
   input  logic signed [WIDTH-1:0]   b_r,
   input  logic signed [WIDTH-1:0]   b_i,
   output logic signed [2*WIDTH-1:0] pr_rr,
   output logic signed [2*WIDTH-1:0] pr_ii,
   output logic signed [2*WIDTH-1:0] pr_ri,
   output logic signed [2*WIDTH-1:0] pr_ir
);

   localparam int PW = 2 * WIDTH;

   // products -> p1 (data only, no reset)
   always_ff @(posedge clk) begin
      if (en) begin
         pr_rr <= PW'(a_r) * PW'(b_r);
         pr_ii <= PW'(a_i) * PW'(b_i);
         pr_ri <= PW'(a_r) * PW'(b_i);
         pr_ir <= PW'(a_i) * PW'(b_r);
      end
   end

endmodule

// File: rtl/cplx_recursion.sv
// ---------------------------------------------------------------------------
// cplx_recursion
// First-order complex recursion m[k] = LAMBDA*m[k-1] + f[k], m[-1] = 0.
// One sample every 3 cycles: accept (IDLE) -> products (MUL) -> round, add,
// saturate and write back (ADD). Result appears 2 cycles after acceptance.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of state, sat and any in-flight sample
//   in_valid   in_data holds a valid LUT sum
//   in_ready   sample accepted this cycle when in_valid is also high
//   in_data    f[k], {r, i}, each signed WIDTH with FRAC fractional bits
//   out_valid  out_data holds a valid result
//   out_ready  downstream accepts out_data this cycle
//   out_data   m[k], {r, i}
//   sat        sticky: a component clipped since last reset or clear
// ---------------------------------------------------------------------------
module cplx_recursion
   import cplx_recursion_pkg::*;
#(
   parameter int  WIDTH     = FILT_W,
   parameter int  FRAC      = FILT_FRAC,
   parameter real LAMBDA_RE = 0.5,
   parameter real LAMBDA_IM = 0.0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_data,
   output logic               sat
);

   localparam int SW = 2 * WIDTH + 2;

   localparam longint LRE_L = to_fixed(LAMBDA_RE, FRAC);
   localparam longint LIM_L = to_fixed(LAMBDA_IM, FRAC);
   localparam logic signed [WIDTH-1:0] LRE = LRE_L[WIDTH-1:0];
   localparam logic signed [WIDTH-1:0] LIM = LIM_L[WIDTH-1:0];

   localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC - 1);
   localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;

   // Round half-up: add one half LSB, then arithmetic shift.
   function automatic logic signed [SW-1:0] rnd(input logic signed [SW-1:0] x);
      return (x + HALF) >>> FRAC;
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_w(input  logic signed [SW-1:0] x,
                                                     output logic                 clip);
      logic signed [SW-1:0] y;
      clip = 1'b0;
      y    = x;
      if (x > MAXV) begin
         clip = 1'b1;
         y    = MAXV;
      end else if (x < MINV) begin
         clip = 1'b1;
         y    = MINV;
      end
      return y[WIDTH-1:0];
   endfunction

   rec_state_t state;
   logic       live;

   logic signed [WIDTH-1:0]   m_r, m_i;
   logic signed [WIDTH-1:0]   f_r_p0, f_i_p0;
   logic signed [2*WIDTH-1:0] pr_rr_p1, pr_ii_p1, pr_ri_p1, pr_ir_p1;

   logic signed [SW-1:0]    acc_r, acc_i;
   logic signed [WIDTH-1:0] add_r, add_i;
   logic                    clip_r, clip_i;
   logic                    accept, mul_en;

   // live keeps in_ready low until the first edge after reset release.
   assign in_ready = live && (state == IDLE) && (!out_valid || out_ready) && !clear;
   assign accept   = in_valid && in_ready;
   assign mul_en   = (state == MUL);

   // accept -> p0: capture f (data only, no reset)
   always_ff @(posedge clk) begin
      if (accept) begin
         f_r_p0 <= in_data[2*WIDTH-1:WIDTH];
         f_i_p0 <= in_data[WIDTH-1:0];
      end
   end

   // MUL -> p1: LAMBDA * m partial products
   cplx_mult #(
      .WIDTH (WIDTH)
   ) u_mult (
      .clk   (clk),
      .en    (mul_en),
      .a_r   (LRE),
      .a_i   (LIM),
      .b_r   (m_r),
      .b_i   (m_i),
      .pr_rr (pr_rr_p1),
      .pr_ii (pr_ii_p1),
      .pr_ri (pr_ri_p1),
      .pr_ir (pr_ir_p1)
   );

   // ADD: combine, round, add f, saturate
   always_comb begin
      clip_r = 1'b0;
      clip_i = 1'b0;
      acc_r  = rnd(SW'(pr_rr_p1) - SW'(pr_ii_p1)) + SW'(f_r_p0);
      acc_i  = rnd(SW'(pr_ri_p1) + SW'(pr_ir_p1)) + SW'(f_i_p0);
      add_r  = sat_w(acc_r, clip_r);
      add_i  = sat_w(acc_i, clip_i);
   end

   // ADD -> write-back to m / out_data; clear outranks every other event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         live      <= 1'b0;
         m_r       <= '0;
         m_i       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         live <= 1'b1;
         if (clear) begin
            state     <= IDLE;
            m_r       <= '0;
            m_i       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
            case (state)
               IDLE: begin
                  if (accept) begin
                     state <= MUL;
                  end
               end
               MUL: begin
                  state <= ADD;
               end
               ADD: begin
                  m_r       <= add_r;
                  m_i       <= add_i;
                  out_data  <= {add_r, add_i};
                  out_valid <= 1'b1;
                  sat       <= sat | clip_r | clip_i;
                  state     <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cplx_recursion.sv
// ---------------------------------------------------------------------------
// tb_cplx_recursion
// Three instances (WIDTH=16, FRAC=12) with LAMBDA = 0.5, 1j and 1.0. One
// instance is observed at a time (sel); expected results are queued on
// acceptance and compared when the observed instance hands out a result.
// ---------------------------------------------------------------------------
module tb_cplx_recursion;

   localparam int W  = 16;
   localparam int FR = 12;
   localparam int DW = 2 * W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;

   logic          in_valid  [3];
   logic          in_ready  [3];
   logic [DW-1:0] in_data   [3];
   logic          out_valid [3];
   logic          out_ready [3];
   logic [DW-1:0] out_data  [3];
   logic          sat       [3];

   always #5 clk = ~clk;

   cplx_recursion #(.WIDTH(W), .FRAC(FR), .LAMBDA_RE(0.5), .LAMBDA_IM(0.0)) u_step (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .sat(sat[0]));

   cplx_recursion #(.WIDTH(W), .FRAC(FR), .LAMBDA_RE(0.0), .LAMBDA_IM(1.0)) u_rot (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .sat(sat[1]));

   cplx_recursion #(.WIDTH(W), .FRAC(FR), .LAMBDA_RE(1.0), .LAMBDA_IM(0.0)) u_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .sat(sat[2]));

   typedef struct {
      int dut;
      int fr;
      int fi;
      int er;
      int ei;
      bit es;
      bit lat;
   } vec_t;

   typedef struct {
      int er;
      int ei;
      bit es;
      bit lat;
      int acc;
   } exp_t;

   vec_t tbl [9];
   exp_t sbq [$];
   exp_t mon_e;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   int sel   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // Scoreboard: compare every handed-out result of the observed instance.
   always @(negedge clk) begin
      if (out_valid[sel] && out_ready[sel]) begin
         if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output: got out_valid=1 on dut %0d, expected none", sel);
         end else begin
            mon_e = sbq.pop_front();
            check("out_re", int'($signed(out_data[sel][DW-1:W])), mon_e.er);
            check("out_im", int'($signed(out_data[sel][W-1:0])), mon_e.ei);
            check("out_sat", int'(sat[sel]), int'(mon_e.es));
            if (mon_e.lat) check("latency", cyc - mon_e.acc, 2);
         end
      end
   end

   task automatic send(input int d, input int fr, input int fi, input bit push,
                       input int er, input int ei, input bit es, input bit lat);
      exp_t e;
      bit   done;
      done       = 1'b0;
      in_data[d] = {16'(fr), 16'(fi)};
      in_valid[d] = 1'b1;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            done        = 1'b1;
            if (push) begin
               e.er  = er;
               e.ei  = ei;
               e.es  = es;
               e.lat = lat;
               e.acc = cyc;
               sbq.push_back(e);
            end
         end
      end
      if (!done) begin
         in_valid[d] = 1'b0;
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready stayed 0 on dut %0d, expected 1", d);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 30 && sbq.size() != 0; t++) @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      int prev;
      logic [DW-1:0] held;
      bit seen;

      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
      end

      //            dut  f_r    f_i  exp_r  exp_i sat lat
      tbl[0] = '{0, 4096,  0,  4096,     0, 1'b0, 1'b1};
      tbl[1] = '{0, 4096,  0,  6144,     0, 1'b0, 1'b1};
      tbl[2] = '{0, 4096,  0,  7168,     0, 1'b0, 1'b1};
      tbl[3] = '{1, 4096,  0,  4096,     0, 1'b0, 1'b0};
      tbl[4] = '{1,    0,  0,     0,  4096, 1'b0, 1'b0};
      tbl[5] = '{1,    0,  0, -4096,     0, 1'b0, 1'b0};
      tbl[6] = '{1,    0,  0,     0, -4096, 1'b0, 1'b0};
      tbl[7] = '{2, 30000, 0, 30000,     0, 1'b0, 1'b0};
      tbl[8] = '{2, 30000, 0, 32767,     0, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid[0]), 0);
      check("rst_in_ready", int'(in_ready[0]), 0);
      check("rst_sat", int'(sat[0]), 0);
      check("rst_out_data", int'(out_data[0]), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", int'(in_ready[0]), 1);

      // Table: step, rotation, saturation
      prev = -1;
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].dut != prev) begin
            drain();
            sel  = tbl[i].dut;
            prev = tbl[i].dut;
            do_clear();
         end
         send(tbl[i].dut, tbl[i].fr, tbl[i].fi, 1'b1,
              tbl[i].er, tbl[i].ei, tbl[i].es, tbl[i].lat);
      end
      drain();

      // Sticky sat, clear with coincident in_valid, recovery
      check("sat_sticky", int'(sat[2]), 1);
      clear       = 1'b1;
      in_data[2]  = {16'(100), 16'(0)};
      in_valid[2] = 1'b1;
      @(negedge clk);
      check("in_ready_during_clear", int'(in_ready[2]), 0);
      @(posedge clk);
      #1;
      clear       = 1'b0;
      in_valid[2] = 1'b0;
      check("sat_after_clear", int'(sat[2]), 0);
      check("out_valid_after_clear", int'(out_valid[2]), 0);
      send(2, 100, 0, 1'b1, 100, 0, 1'b0, 1'b0);
      drain();

      // Backpressure
      sel = 0;
      do_clear();
      out_ready[0] = 1'b0;
      send(0, 4096, 0, 1'b1, 4096, 0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(posedge clk);
         #1;
         seen = out_valid[0];
      end
      check("bp_out_valid_seen", int'(seen), 1);
      held = out_data[0];
      for (int t = 0; t < 5; t++) begin
         @(posedge clk);
         #1;
         check("bp_data_stable", int'(out_data[0]), int'(held));
         check("bp_valid_held", int'(out_valid[0]), 1);
         check("bp_in_ready_low", int'(in_ready[0]), 0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      check("bp_in_ready_release", int'(in_ready[0]), 1);
      check("bp_valid_cleared", int'(out_valid[0]), 0);
      drain();

      // Reset during MUL: sample must vanish
      send(0, 4096, 0, 1'b0, 0, 0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mul_out_valid", int'(out_valid[0]), 0);
      check("rst_mul_in_ready", int'(in_ready[0]), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk);
         #1;
         check("no_out_after_reset", int'(out_valid[0]), 0);
      end

      // Clear during ADD: sample must vanish
      send(0, 4096, 0, 1'b0, 0, 0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      do_clear();
      for (int t = 0; t < 3; t++) begin
         @(posedge clk);
         #1;
         check("no_out_after_clear", int'(out_valid[0]), 0);
      end
      send(0, 4096, 0, 1'b1, 4096, 0, 1'b0, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
